// File: rtl/cruise_control_unit_p_pkg.sv
// cruise_pkg: shared types and helpers for the cruise-control core.
//   state_t         : supervisor FSM states
//   MODE_*          : driver mode / counter command encodings
//   is_awake        : consc_level 1xx
//   is_unconscious  : consc_level 000 (001..011 is drowsy)
package cruise_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CRUISE  = 2'b01,
    ALERT   = 2'b10,
    BRAKING = 2'b11
  } state_t;

  // Also used as the command encoding of sat_step_counter.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  function automatic logic is_awake(input logic [2:0] consc);
    return consc[2];
  endfunction

  function automatic logic is_unconscious(input logic [2:0] consc);
    return (consc == 3'b000);
  endfunction

endpackage

// File: rtl/cruise_control_unit_p_sat_step_counter.sv
// sat_step_counter: register with hold / load / step-up / step-down commands.
// Stepping up saturates at MAX, stepping down saturates at 0.
// Ports:
//   clk      : clock
//   clear    : asynchronous active-low reset (q -> 0)
//   cmd      : MODE_HOLD, MODE_LOAD, MODE_UP, MODE_DOWN
//   load_val : value taken on MODE_LOAD
//   q        : registered count
module sat_step_counter
  import cruise_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int MAX   = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] MAX_X  = (WIDTH + 1)'(MAX);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    // One extra bit so the overflow of q+STEP is visible to the compare.
    sum   = {1'b0, q} + STEP_X;
    q_nxt = q;
    case (cmd)
      MODE_LOAD: q_nxt = load_val;
      MODE_UP:   q_nxt = (sum > MAX_X) ? MAX_X[WIDTH-1:0] : sum[WIDTH-1:0];
      MODE_DOWN: q_nxt = ({1'b0, q} < STEP_X) ? '0 : (q - STEP_X[WIDTH-1:0]);
      default:   q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) q <= '0;
    else        q <= q_nxt;
  end

endmodule

// File: rtl/cruise_control_unit_p.sv
// cruise_control_unit_p: cruise-control core. Holds the driver target speed,
// regulates a saturating fuel command against the measured speed, and
// supervises driver consciousness, escalating drowsiness/unconsciousness to
// braking.
// Ports:
//   clk           : clock
//   clear         : asynchronous active-low reset
//   current_speed : measured speed
//   mode          : 00 hold, 01 load current_speed, 10 step up, 11 step down
//   consc_level   : 1xx awake, 001..011 drowsy, 000 unconscious
//   brake         : registered brake command
//   fuel_level    : registered throttle command
//   default_speed : registered target speed
//   engaged       : registered, high in CRUISE or ALERT
//
// state   | meaning
// IDLE    | driver in control, outputs quiet, waits for a target load
// CRUISE  | driver awake, fuel regulated toward default_speed
// ALERT   | driver drowsy, fuel bleeds down while dcnt counts drowsy samples
// BRAKING | brake applied, fuel held at 0 until an awake sample
module cruise_control_unit_p
  import cruise_pkg::*;
#(
  parameter int SPEED_W       = 8,
  parameter int FUEL_W        = 3,
  parameter int STEP          = 5,
  parameter int SPEED_MAX     = (2 ** SPEED_W) - 1,
  parameter int DROWSY_CYCLES = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [SPEED_W-1:0] current_speed,
  input  logic [1:0]         mode,
  input  logic [2:0]         consc_level,
  output logic               brake,
  output logic [FUEL_W-1:0]  fuel_level,
  output logic [SPEED_W-1:0] default_speed,
  output logic               engaged
);

  localparam int DCNT_W = $clog2(DROWSY_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DROWSY_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

  state_t            state;
  logic [DCNT_W-1:0] dcnt;

  logic       awake, unconscious, drowsy;
  logic       at_limit, go_brake;
  logic [1:0] tgt_cmd, fuel_cmd;

  always_comb begin
    awake       = is_awake(consc_level);
    unconscious = is_unconscious(consc_level);
    drowsy      = !awake && !unconscious;

    // With a one-sample timeout the CRUISE->ALERT sample is already the last.
    at_limit = ((state == CRUISE) && (DROWSY_CYCLES == 1)) ||
               ((state == ALERT) && (dcnt == DCNT_LAST));
    go_brake = ((state == CRUISE) || (state == ALERT)) &&
               (unconscious || (drowsy && at_limit));

    tgt_cmd = ((state == IDLE) && (mode != MODE_LOAD)) ? MODE_HOLD : mode;

    // Compare uses the registered target, not the value loaded this edge.
    fuel_cmd = MODE_HOLD;
    case (state)
      CRUISE: begin
        if (go_brake)                           fuel_cmd = MODE_LOAD;
        else if (drowsy)                        fuel_cmd = MODE_DOWN;
        else if (current_speed < default_speed) fuel_cmd = MODE_UP;
        else if (current_speed > default_speed) fuel_cmd = MODE_DOWN;
        else                                    fuel_cmd = MODE_HOLD;
      end
      ALERT:   fuel_cmd = go_brake ? MODE_LOAD : MODE_DOWN;
      default: fuel_cmd = MODE_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      dcnt    <= '0;
      brake   <= 1'b0;
      engaged <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mode == MODE_LOAD) begin
            state   <= CRUISE;
            engaged <= 1'b1;
          end
        end
        CRUISE, ALERT: begin
          if (go_brake) begin
            state   <= BRAKING;
            dcnt    <= '0;
            brake   <= 1'b1;
            engaged <= 1'b0;
          end else if (awake) begin
            state <= CRUISE;
            dcnt  <= '0;
          end else if (state == CRUISE) begin
            state <= ALERT;
            dcnt  <= DCNT_ONE;
          end else begin
            dcnt <= dcnt + DCNT_ONE;
          end
        end
        BRAKING: begin
          dcnt <= '0;
          if (awake) begin
            state   <= CRUISE;
            brake   <= 1'b0;
            engaged <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          dcnt    <= '0;
          brake   <= 1'b0;
          engaged <= 1'b0;
        end
      endcase
    end
  end

  sat_step_counter #(
    .WIDTH (SPEED_W),
    .STEP  (STEP),
    .MAX   (SPEED_MAX)
  ) u_target (
    .clk      (clk),
    .clear    (clear),
    .cmd      (tgt_cmd),
    .load_val (current_speed),
    .q        (default_speed)
  );

  sat_step_counter #(
    .WIDTH (FUEL_W),
    .STEP  (1),
    .MAX   ((2 ** FUEL_W) - 1)
  ) u_fuel (
    .clk      (clk),
    .clear    (clear),
    .cmd      (fuel_cmd),
    .load_val ('0),
    .q        (fuel_level)
  );

endmodule
